// File: rtl/matmul_sequencer_if.sv
// Control/address bundle between the matmul sequencer and the MAC datapath / A, B, C memories.
interface matmul_sequencer_if #(
    parameter int AW = 4
) ();
    logic          start;
    logic          stall;
    logic          rd_en;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic          mac_en;
    logic          mac_clear;
    logic          c_wr_en;
    logic [AW-1:0] c_addr;
    logic          busy;
    logic          done;

    modport master (
        input  start, stall,
        output rd_en, a_addr, b_addr, mac_en, mac_clear, c_wr_en, c_addr, busy, done
    );

    modport slave (
        output start, stall,
        input  rd_en, a_addr, b_addr, mac_en, mac_clear, c_wr_en, c_addr, busy, done
    );
endinterface

// File: rtl/matmul_sequencer.sv
// Sequences C = A*B for square NxN matrices: walks (i,j,k), strobes reads,
// steers the MAC one cycle behind the reads and writes each C element.
module matmul_sequencer #(
    parameter int N  = 4,
    parameter int AW = 4
) (
    input  logic               clock,
    input  logic               reset,
    matmul_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, FIN} state_e;

    localparam logic [AW-1:0] NA   = AW'(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic          rdValid_q, rdValid_d;
    logic          rdFirst_q, rdFirst_d;
    logic          holdActive;

    logic          rdEn, macEn, macClear, cWrEn;
    logic [AW-1:0] aAddr, bAddr, cAddr;

    // stall only freezes the working states; IDLE and FIN never wait on the datapath
    assign holdActive = bus.stall && (state_q == READ || state_q == DRAIN || state_q == WRITE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            rdValid_q <= 1'b0;
            rdFirst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            rdValid_q <= rdValid_d;
            rdFirst_q <= rdFirst_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        rdValid_d = rdValid_q;
        rdFirst_d = rdFirst_q;
        case (state_q)
            IDLE: begin
                rdValid_d = 1'b0;
                if (bus.start) begin
                    state_d = READ;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            READ: begin
                if (!holdActive) begin
                    rdValid_d = 1'b1;
                    rdFirst_d = (k_q == '0);
                    if (k_q == LAST) begin
                        k_d     = '0;
                        state_d = DRAIN;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!holdActive) begin
                    rdValid_d = 1'b0;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (!holdActive) begin
                    rdValid_d = 1'b0;
                    if (j_q != LAST) begin
                        j_d     = j_q + 1'b1;
                        state_d = READ;
                    end else if (i_q != LAST) begin
                        j_d     = '0;
                        i_d     = i_q + 1'b1;
                        state_d = READ;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                rdValid_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Addresses are zeroed whenever their strobe is low, which also keeps them 0 in IDLE
    always_comb begin
        rdEn     = (state_q == READ) && !holdActive;
        macEn    = rdValid_q && !holdActive && (state_q == READ || state_q == DRAIN);
        macClear = macEn && rdFirst_q;
        cWrEn    = (state_q == WRITE) && !holdActive;
        aAddr    = '0;
        bAddr    = '0;
        cAddr    = '0;
        if (rdEn) begin
            aAddr = i_q * NA + k_q;
            bAddr = k_q * NA + j_q;
        end
        if (cWrEn) begin
            cAddr = i_q * NA + j_q;
        end
    end

    assign bus.rd_en     = rdEn;
    assign bus.a_addr    = aAddr;
    assign bus.b_addr    = bAddr;
    assign bus.mac_en    = macEn;
    assign bus.mac_clear = macClear;
    assign bus.c_wr_en   = cWrEn;
    assign bus.c_addr    = cAddr;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == FIN);
endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: N=2 and N=4 instances checked every cycle against a
// step-count model, plus hand-computed literal expectations on recorded traces.
module tb_matmul_sequencer;
    logic clock = 1'b0;
    logic reset2, reset4;
    int   cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    matmul_sequencer_if #(.AW(4)) bus2 ();
    matmul_sequencer_if #(.AW(4)) bus4 ();

    matmul_sequencer #(.N(2), .AW(4)) dut2 (.clock(clock), .reset(reset2), .bus(bus2.master));
    matmul_sequencer #(.N(4), .AW(4)) dut4 (.clock(clock), .reset(reset4), .bus(bus4.master));

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rd_en;
        logic       mac_en;
        logic       mac_clear;
        logic       c_wr_en;
        logic [3:0] a_addr;
        logic [3:0] b_addr;
        logic [3:0] c_addr;
    } obs_t;

    obs_t obs2, obs4;
    assign obs2 = {bus2.busy, bus2.done, bus2.rd_en, bus2.mac_en, bus2.mac_clear,
                   bus2.c_wr_en, bus2.a_addr, bus2.b_addr, bus2.c_addr};
    assign obs4 = {bus4.busy, bus4.done, bus4.rd_en, bus4.mac_en, bus4.mac_clear,
                   bus4.c_wr_en, bus4.a_addr, bus4.b_addr, bus4.c_addr};

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkOn     = 1'b0;

    bit running [2];
    int step    [2];

    bit   stimStart [256];
    bit   stimStall [256];
    bit   stimReset [256];
    obs_t trace     [256];

    // A run is a count of unstalled steps: element e owns steps e*(N+2)+1 .. e*(N+2)+N+2,
    // N reads, then drain, then write; the step after the last element is the done pulse.
    function automatic obs_t modelOut(input int n, input bit run, input int t, input bit stl);
        obs_t o;
        int   per, e, ph, i, j;
        o   = '0;
        per = n + 2;
        if (!run) return o;
        o.busy = 1'b1;
        if (t == n * n * per + 1) begin
            o.done = 1'b1;
            return o;
        end
        if (stl) return o;
        e  = (t - 1) / per;
        ph = (t - 1) % per;
        i  = e / n;
        j  = e % n;
        if (ph < n) begin
            o.rd_en  = 1'b1;
            o.a_addr = 4'(i * n + ph);
            o.b_addr = 4'(ph * n + j);
        end
        if (ph >= 1 && ph <= n) begin
            o.mac_en    = 1'b1;
            o.mac_clear = (ph == 1);
        end
        if (ph == n + 1) begin
            o.c_wr_en = 1'b1;
            o.c_addr  = 4'(e);
        end
        return o;
    endfunction

    task automatic advance(input int idx, input int n, input logic rst, input logic st, input logic stl);
        if (rst) begin
            running[idx] = 1'b0;
        end else if (!running[idx]) begin
            if (st) begin
                running[idx] = 1'b1;
                step[idx]    = 1;
            end
        end else if (step[idx] == n * n * (n + 2) + 1) begin
            running[idx] = 1'b0;
        end else if (!stl) begin
            step[idx] = step[idx] + 1;
        end
    endtask

    always @(posedge clock) begin
        advance(0, 2, reset2, bus2.start, bus2.stall);
        advance(1, 4, reset4, bus4.start, bus4.stall);
    end

    task automatic compareObs(input string tag, input obs_t act, input obs_t want);
        bit bad;
        bad = ({act.busy, act.done, act.rd_en, act.mac_en, act.mac_clear, act.c_wr_en} !==
               {want.busy, want.done, want.rd_en, want.mac_en, want.mac_clear, want.c_wr_en});
        if (want.rd_en && (act.a_addr !== want.a_addr || act.b_addr !== want.b_addr)) bad = 1'b1;
        if (want.c_wr_en && act.c_addr !== want.c_addr) bad = 1'b1;
        if (!want.busy && {act.a_addr, act.b_addr, act.c_addr} !== 12'd0) bad = 1'b1;
        testsRun++;
        if (bad) begin
            testsFailed++;
            $display("[TB] FAIL %s cycle %0d: got %h want %h", tag, cyc, act, want);
        end
    endtask

    always @(negedge clock) begin
        if (checkOn) begin
            compareObs("model_n2", obs2, modelOut(2, running[0], step[0], bus2.stall));
            compareObs("model_n4", obs4, modelOut(4, running[1], step[1], bus4.stall));
        end
    end

    task automatic checkOutput(input string name, input int act, input int want);
        testsRun++;
        if (act != want) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic clearStim();
        for (int c = 0; c < 256; c++) begin
            stimStart[c] = 1'b0;
            stimStall[c] = 1'b0;
            stimReset[c] = 1'b0;
        end
    endtask

    // Called just after a rising edge; relative cycle 0 is the cycle that follows
    task automatic applyStimulus(input int sel, input int len);
        for (int c = 0; c < len; c++) begin
            if (sel == 0) begin
                bus2.start = stimStart[c];
                bus2.stall = stimStall[c];
                reset2     = stimReset[c];
            end else begin
                bus4.start = stimStart[c];
                bus4.stall = stimStall[c];
                reset4     = stimReset[c];
            end
            @(negedge clock);
            trace[c] = (sel == 0) ? obs2 : obs4;
            @(posedge clock);
            #1;
        end
        bus2.start = 1'b0; bus2.stall = 1'b0; reset2 = 1'b0;
        bus4.start = 1'b0; bus4.stall = 1'b0; reset4 = 1'b0;
    endtask

    function automatic int strobes(input obs_t o);
        return int'(o.rd_en | o.mac_en | o.mac_clear | o.c_wr_en);
    endfunction

    int rdCyc [8] = '{1, 2, 5, 6, 9, 10, 13, 14};
    int aExp  [8] = '{0, 1, 0, 1, 2, 3, 2, 3};
    int bExp  [8] = '{0, 2, 1, 3, 0, 2, 1, 3};

    initial begin
        int cnt;
        reset2 = 1'b1; reset4 = 1'b1;
        bus2.start = 1'b0; bus2.stall = 1'b0;
        bus4.start = 1'b0; bus4.stall = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOn = 1'b1;
        reset2  = 1'b0;
        reset4  = 1'b0;

        // Idle after reset: nothing moves
        clearStim();
        applyStimulus(0, 10);
        cnt = 0;
        for (int c = 0; c < 10; c++) if (trace[c] != '0) cnt++;
        checkOutput("idle_quiet", cnt, 0);

        // Plain N=2 run
        clearStim();
        stimStart[0] = 1'b1;
        applyStimulus(0, 20);
        for (int x = 0; x < 8; x++) begin
            checkOutput("n2_rd_en", int'(trace[rdCyc[x]].rd_en), 1);
            checkOutput("n2_a_addr", int'(trace[rdCyc[x]].a_addr), aExp[x]);
            checkOutput("n2_b_addr", int'(trace[rdCyc[x]].b_addr), bExp[x]);
        end
        for (int x = 0; x < 4; x++) begin
            checkOutput("n2_c_wr_en", int'(trace[4 + 4 * x].c_wr_en), 1);
            checkOutput("n2_c_addr", int'(trace[4 + 4 * x].c_addr), x);
            checkOutput("n2_mac_clear", int'(trace[2 + 4 * x].mac_clear & trace[2 + 4 * x].mac_en), 1);
        end
        cnt = 0;
        for (int c = 0; c < 20; c++) cnt += int'(trace[c].mac_clear);
        checkOutput("n2_mac_clear_count", cnt, 4);
        cnt = 0;
        for (int c = 0; c < 20; c++) cnt += int'(trace[c].c_wr_en);
        checkOutput("n2_c_wr_count", cnt, 4);
        checkOutput("n2_done_17", int'(trace[17].done), 1);
        checkOutput("n2_done_16", int'(trace[16].done), 0);
        checkOutput("n2_busy_18", int'(trace[18].busy), 0);

        // Three-cycle stall on the second read of element 0
        clearStim();
        stimStart[0] = 1'b1;
        stimStall[2] = 1'b1; stimStall[3] = 1'b1; stimStall[4] = 1'b1;
        applyStimulus(0, 23);
        for (int c = 2; c <= 4; c++) begin
            checkOutput("stall_no_strobe", strobes(trace[c]), 0);
            checkOutput("stall_busy", int'(trace[c].busy), 1);
        end
        checkOutput("stall_resume_rd", int'(trace[5].rd_en), 1);
        checkOutput("stall_resume_a", int'(trace[5].a_addr), 1);
        checkOutput("stall_resume_b", int'(trace[5].b_addr), 2);
        checkOutput("stall_resume_clear", int'(trace[5].mac_clear), 1);
        checkOutput("stall_wr_c0", int'(trace[7].c_wr_en), 1);
        checkOutput("stall_done_19", int'(trace[19].done), 0);
        checkOutput("stall_done_20", int'(trace[20].done), 1);

        // Extra start pulses mid-run and in FIN are ignored
        clearStim();
        stimStart[0] = 1'b1; stimStart[5] = 1'b1; stimStart[17] = 1'b1;
        applyStimulus(0, 22);
        cnt = 0;
        for (int c = 0; c < 22; c++) cnt += int'(trace[c].done);
        checkOutput("restart_one_done", cnt, 1);
        checkOutput("restart_done_17", int'(trace[17].done), 1);
        checkOutput("restart_busy_18", int'(trace[18].busy), 0);

        // N=4: reset mid-run, then a full run from a fresh start
        clearStim();
        stimStart[0]  = 1'b1;
        stimReset[40] = 1'b1;
        stimStart[45] = 1'b1;
        applyStimulus(1, 150);
        checkOutput("n4_busy_40", int'(trace[40].busy), 1);
        checkOutput("n4_reset_idle_41", int'(trace[41]), 0);
        checkOutput("n4_rd_a_48", int'(trace[48].a_addr), 2);
        checkOutput("n4_rd_b_48", int'(trace[48].b_addr), 8);
        checkOutput("n4_wr_51", int'(trace[51].c_wr_en), 1);
        checkOutput("n4_rd_a_79", int'(trace[79].a_addr), 7);
        checkOutput("n4_rd_b_79", int'(trace[79].b_addr), 13);
        checkOutput("n4_done_141", int'(trace[141].done), 0);
        checkOutput("n4_done_142", int'(trace[142].done), 1);
        checkOutput("n4_busy_143", int'(trace[143].busy), 0);

        repeat (2) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
